// File: rtl/tdm_mux_param.sv
// -----------------------------------------------------------------------------
// tdm_mux_param
// Round-robin time-division multiplexer. NCH input channels of width W share
// one output bus. Each enabled channel occupies SLOT_CYCLES cycles per frame.
// Disabled channels are skipped. The channel mask and the run request are
// taken only in IDLE and at frame boundaries, so every frame is complete.
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   en          run request, sampled in IDLE and at frame boundaries
//   ch_mask     per-channel enable, bit k serves channel k
//   in_bus      packed channel data, channel k at [k*W +: W]
//   out_data    registered data of the channel being served
//   out_ch      index of the channel on out_data
//   out_valid   out_data/out_ch are meaningful
//   frame_start high on every cycle of the first slot of a frame
// -----------------------------------------------------------------------------
module tdm_mux_param #(
    parameter int unsigned  NCH         = 4,
    parameter int unsigned  W           = 8,
    parameter int unsigned  SLOT_CYCLES = 1,
    localparam int unsigned CH_W        = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NCH-1:0]    ch_mask,
    input  logic [NCH*W-1:0]  in_bus,
    output logic [W-1:0]      out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_valid,
    output logic              frame_start
);

    // Keep the slot counter at least one bit wide when SLOT_CYCLES is 1.
    localparam int unsigned CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
    logic [CNT_W-1:0]  slot_cnt_q, slot_cnt_d;
    logic [NCH-1:0]    mask_q, mask_d;
    logic              first_q, first_d;
    logic [W-1:0]      out_data_d;
    logic [CH_W-1:0]   out_ch_d;
    logic              out_valid_d;
    logic              frame_start_d;

    logic [W-1:0]      sel_data;
    logic [CH_W-1:0]   new_first_ch;
    logic [CH_W-1:0]   next_ch;
    logic              next_found;
    logic              start_ok;

    // Data of the channel currently served.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            if (cur_ch_q == CH_W'(k)) begin
                sel_data = in_bus[k*W +: W];
            end
        end
    end

    // Lowest set bit of the incoming mask (first channel of a new frame).
    always_comb begin
        new_first_ch = '0;
        for (int k = int'(NCH) - 1; k >= 0; k--) begin
            if (ch_mask[k]) begin
                new_first_ch = CH_W'(k);
            end
        end
    end

    // Next set bit of the latched mask strictly above the current channel.
    always_comb begin
        next_ch    = '0;
        next_found = 1'b0;
        for (int k = int'(NCH) - 1; k >= 0; k--) begin
            if (mask_q[k] && (k > int'(cur_ch_q))) begin
                next_ch    = CH_W'(k);
                next_found = 1'b1;
            end
        end
    end

    assign start_ok = en && (|ch_mask);

    always_comb begin
        state_d       = state_q;
        cur_ch_d      = cur_ch_q;
        slot_cnt_d    = slot_cnt_q;
        mask_d        = mask_q;
        first_d       = first_q;
        out_data_d    = out_data;
        out_ch_d      = out_ch;
        out_valid_d   = 1'b0;
        frame_start_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d    = StRun;
                    mask_d     = ch_mask;
                    cur_ch_d   = new_first_ch;
                    slot_cnt_d = '0;
                    first_d    = 1'b1;
                end
            end
            StRun: begin
                out_data_d    = sel_data;
                out_ch_d      = cur_ch_q;
                out_valid_d   = 1'b1;
                frame_start_d = first_q;
                if (slot_cnt_q == CNT_W'(SLOT_CYCLES - 1)) begin
                    slot_cnt_d = '0;
                    first_d    = 1'b0;
                    if (next_found) begin
                        cur_ch_d = next_ch;
                    end else if (start_ok) begin
                        // Frame boundary: pick up the new mask, no bubble.
                        mask_d   = ch_mask;
                        cur_ch_d = new_first_ch;
                        first_d  = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    slot_cnt_d = slot_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cur_ch_q    <= '0;
            slot_cnt_q  <= '0;
            mask_q      <= '0;
            first_q     <= 1'b0;
            out_data    <= '0;
            out_ch      <= '0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_ch_q    <= cur_ch_d;
            slot_cnt_q  <= slot_cnt_d;
            mask_q      <= mask_d;
            first_q     <= first_d;
            out_data    <= out_data_d;
            out_ch      <= out_ch_d;
            out_valid   <= out_valid_d;
            frame_start <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_tdm_mux_param.sv
// -----------------------------------------------------------------------------
// tb_tdm_mux_param
// Two instances: A (NCH=4, W=8, SLOT_CYCLES=1) and B (NCH=3, W=5,
// SLOT_CYCLES=3). Each is compared every cycle against a frame-level model:
// a frame is the list of enabled channels, each repeated SLOT_CYCLES times,
// walked by a position counter.
// -----------------------------------------------------------------------------
module tb_tdm_mux_param;

    logic        clk;
    logic        rst;

    logic        en_a;
    logic [3:0]  mask_a;
    logic [31:0] bus_a;
    logic [7:0]  data_a;
    logic [1:0]  ch_a;
    logic        valid_a;
    logic        fs_a;

    logic        en_b;
    logic [2:0]  mask_b;
    logic [14:0] bus_b;
    logic [4:0]  data_b;
    logic [1:0]  ch_b;
    logic        valid_b;
    logic        fs_b;

    int n_checks;
    int n_errors;
    bit inc_b;

    // Model state per instance (0 = A, 1 = B).
    bit run_m   [2];
    int fmask_m [2];
    int pos_m   [2];
    int e_data  [2];
    int e_ch    [2];
    int e_valid [2];
    int e_fs    [2];

    tdm_mux_param #(.NCH(4), .W(8), .SLOT_CYCLES(1)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .en          (en_a),
        .ch_mask     (mask_a),
        .in_bus      (bus_a),
        .out_data    (data_a),
        .out_ch      (ch_a),
        .out_valid   (valid_a),
        .frame_start (fs_a)
    );

    tdm_mux_param #(.NCH(3), .W(5), .SLOT_CYCLES(3)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .en          (en_b),
        .ch_mask     (mask_b),
        .in_bus      (bus_b),
        .out_data    (data_b),
        .out_ch      (ch_b),
        .out_valid   (valid_b),
        .frame_start (fs_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int nth_set(input int m, input int n);
        int cnt;
        cnt = n;
        for (int k = 0; k < 32; k++) begin
            if (m[k]) begin
                if (cnt == 0) return k;
                cnt--;
            end
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            run_m[i]   = 1'b0;
            fmask_m[i] = 0;
            pos_m[i]   = 0;
            e_data[i]  = 0;
            e_ch[i]    = 0;
            e_valid[i] = 0;
            e_fs[i]    = 0;
        end
    endtask

    // One clock edge of the model, using the inputs present at that edge.
    task automatic model_step(input int i, input bit en, input int mask,
                              input logic [31:0] bus, input int w, input int s);
        int ch;
        if (run_m[i]) begin
            ch         = nth_set(fmask_m[i], pos_m[i] / s);
            e_ch[i]    = ch;
            e_data[i]  = int'((bus >> (ch * w)) & ((32'd1 << w) - 32'd1));
            e_valid[i] = 1;
            e_fs[i]    = (pos_m[i] < s) ? 1 : 0;
            pos_m[i]++;
            if (pos_m[i] == $countones(fmask_m[i]) * s) begin
                if (en && mask != 0) begin
                    fmask_m[i] = mask;
                    pos_m[i]   = 0;
                end else begin
                    run_m[i] = 1'b0;
                end
            end
        end else begin
            e_valid[i] = 0;
            e_fs[i]    = 0;
            if (en && mask != 0) begin
                run_m[i]   = 1'b1;
                fmask_m[i] = mask;
                pos_m[i]   = 0;
            end
        end
    endtask

    task automatic check_all();
        check("a_valid", int'(valid_a), e_valid[0]);
        check("a_fs",    int'(fs_a),    e_fs[0]);
        check("a_ch",    int'(ch_a),    e_ch[0]);
        check("a_data",  int'(data_a),  e_data[0]);
        check("b_valid", int'(valid_b), e_valid[1]);
        check("b_fs",    int'(fs_b),    e_fs[1]);
        check("b_ch",    int'(ch_b),    e_ch[1]);
        check("b_data",  int'(data_b),  e_data[1]);
        check("b_ch_range", (ch_b < 2'd3) ? 1 : 0, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a_valid"}, int'(valid_a), 0);
        check({tag, "_a_fs"},    int'(fs_a),    0);
        check({tag, "_a_ch"},    int'(ch_a),    0);
        check({tag, "_a_data"},  int'(data_a),  0);
        check({tag, "_b_valid"}, int'(valid_b), 0);
        check({tag, "_b_fs"},    int'(fs_b),    0);
        check({tag, "_b_ch"},    int'(ch_b),    0);
        check({tag, "_b_data"},  int'(data_b),  0);
    endtask

    // Called at a negedge with inputs already driven.
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            model_step(0, en_a, int'(mask_a), bus_a, 8, 1);
            model_step(1, en_b, int'(mask_b), 32'(bus_b), 5, 3);
            @(negedge clk);
            check_all();
            if (inc_b) bus_b[4:0] = bus_b[4:0] + 5'd1;
        end
    endtask

    // Wait (bounded) until A is outputting channel 1.
    task automatic wait_a_ch1();
        int budget;
        budget = 0;
        while (!(valid_a && ch_a == 2'd1) && budget < 16) begin
            run(1);
            budget++;
        end
        check("a_wait_ch1", (valid_a && ch_a == 2'd1) ? 1 : 0, 1);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear at once.
    task automatic pulse_reset(input string tag);
        #1 rst = 1'b1;
        #1 check_zero(tag);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        inc_b    = 1'b0;
        rst      = 1'b1;
        en_a     = 1'b0;
        mask_a   = '0;
        bus_a    = '0;
        en_b     = 1'b0;
        mask_b   = '0;
        bus_b    = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Full sweep on A; B on channels 0/1 with a counting channel 0.
        en_a   = 1'b1;
        mask_a = 4'b1111;
        bus_a  = 32'h33221100;
        en_b   = 1'b1;
        mask_b = 3'b011;
        inc_b  = 1'b1;
        run(12);

        mask_a = 4'b1010;
        run(8);

        // Mask change mid-frame takes effect only at the boundary.
        mask_a = 4'b1111;
        run(3);
        wait_a_ch1();
        mask_a = 4'b0100;
        run(8);

        // en dropped mid-frame: frame completes, then IDLE; then restart.
        mask_a = 4'b1111;
        run(3);
        wait_a_ch1();
        en_a = 1'b0;
        run(6);
        en_a = 1'b1;
        run(6);

        // Reset in the middle of a B slot.
        run(1);
        pulse_reset("midreset");
        inc_b = 1'b0;

        // en with an empty mask never leaves IDLE.
        mask_a = 4'b0000;
        mask_b = 3'b000;
        run(10);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            en_a  = ($urandom_range(0, 9) != 0);
            en_b  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 4) == 0) mask_a = 4'($urandom);
            if ($urandom_range(0, 4) == 0) mask_b = 3'($urandom);
            bus_a = $urandom;
            bus_b = 15'($urandom);
            if (c == 300) begin
                pulse_reset("randreset");
            end else begin
                run(1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tdm_mux_param.md
Name: tdm_mux_param

Overview:
Parametrised time-division multiplexer that serves NCH input channels of width W onto one shared output bus in round-robin slots. Each slot lasts SLOT_CYCLES clock cycles. Disabled channels are skipped. The output carries the channel index, a valid flag and a frame-start marker so that downstream de-framing logic can lock to the slot schedule.

Parameters:
NCH, 4, number of input channels (>=2)
W, 8, data width per channel (>=1)
SLOT_CYCLES, 1, clock cycles each channel occupies the output (>=1)
CH_W, $clog2(NCH), derived localparam, width of the channel index

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
en  input  1  run request; sampled at frame boundaries and in IDLE
ch_mask  input  NCH  per-channel enable; bit k=1 means channel k is served
in_bus  input  NCH*W  channel k occupies bits [k*W +: W]
out_data  output  W  registered data of the currently served channel
out_ch  output  CH_W  index of the channel on out_data
out_valid  output  1  out_data/out_ch are meaningful this cycle
frame_start  output  1  high on every cycle of the first slot of each frame

Behaviour:
- Reset (async, immediate): state=IDLE, cur_ch=0, slot_cnt=0, mask_q=0, out_data=0, out_ch=0, out_valid=0, frame_start=0.
- Internal state: FSM {IDLE, RUN}; cur_ch (CH_W); slot_cnt (0..SLOT_CYCLES-1); mask_q (NCH, frame-latched mask); first_slot flag.
- IDLE:
  - If en=1 and ch_mask!=0: latch mask_q<=ch_mask, cur_ch<=lowest set bit of ch_mask, slot_cnt<=0, first_slot<=1, go to RUN.
  - Otherwise stay in IDLE.
  - Outputs while in IDLE: out_valid<=0, frame_start<=0, out_data/out_ch hold their last values.
- RUN, every edge:
  - out_data<=in_bus[cur_ch], out_ch<=cur_ch, out_valid<=1, frame_start<=first_slot.
  - Data is sampled every cycle, so out_data tracks input changes within a slot with 1-cycle latency.
- Slot advance, when slot_cnt==SLOT_CYCLES-1:
  - slot_cnt<=0, first_slot<=0.
  - cur_ch<=next set bit of mask_q strictly above cur_ch.
  - If no such bit exists, the frame ends:
    - If en=1 and ch_mask!=0: mask_q<=ch_mask, cur_ch<=lowest set bit of the new ch_mask, first_slot<=1, stay in RUN.
    - Otherwise go to IDLE.
- If slot_cnt<SLOT_CYCLES-1: slot_cnt<=slot_cnt+1, and cur_ch is unchanged.
- Latency: if en/ch_mask are accepted at edge E0 (in IDLE), out_valid first rises after edge E0+1.
- ch_mask changes mid-frame are ignored until the frame boundary. No partial frames are produced by a mask change.
- en deasserted mid-frame: the current frame completes over all channels in mask_q, then the block enters IDLE.
- Single enabled channel: the same channel is served every slot, and frame_start is high for SLOT_CYCLES cycles out of every SLOT_CYCLES.
- All-ones mask, SLOT_CYCLES=1: output is a plain cyclic sweep 0..NCH-1 with no gaps.
- No bubbles between frames: out_valid stays high across frame boundaries while en=1 and the mask is non-zero.
- NCH not a power of 2: cur_ch never takes values >=NCH.

Test Plan:
- NCH=4, W=8, SLOT_CYCLES=1, ch_mask=4'b1111, en=1, in_bus={8'h33,8'h22,8'h11,8'h00} -> out_ch 0,1,2,3,0,... on consecutive cycles; out_data 00,11,22,33; frame_start=1 only when out_ch=0; out_valid rises 2 edges after en.
- ch_mask=4'b1010 -> out_ch sequence 1,3,1,3; frame_start high only with out_ch=1; channels 0 and 2 never appear.
- ch_mask switched from 4'b1111 to 4'b0100 while out_ch=1 -> ch2 and ch3 still served, then out_ch=2 every cycle with frame_start=1 each cycle.
- SLOT_CYCLES=3, mask 4'b0011, in0 incremented every cycle -> out_ch 0,0,0,1,1,1; out_data follows in0 with 1-cycle lag during ch0 slots; frame_start high for the 3 ch0 cycles.
- en dropped while out_ch=1 (mask 4'b1111) -> ch2 and ch3 still output; out_valid=0 from the next cycle on; en re-raised -> restart at ch0 with frame_start.
- rst pulsed mid-slot -> all outputs 0 immediately (before the next clk edge); en=1 with ch_mask=0 -> stays IDLE, out_valid=0 indefinitely.
